seq_mul: RTL and testbench
==========================

SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 SHALL have parameter: BW, 16, operand width in bits (BW >= 4).
REQ-002 SHALL have port: clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a multiply; sampled on the rising edge of clk.
REQ-005 SHALL have port: sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have ports: a, b  input  BW  multiplicand and multiplier; sampled with start.
REQ-007 SHALL have port: busy  output  1  high while an operation is iterating.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; prod is valid.
REQ-009 SHALL have port: prod  output  2*BW  registered product.
REQ-010 SHALL have ports: zero, neg  output  1 each  product flags, registered with prod.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL accept start only in IDLE or DONE; start in RUN is ignored, with no effect on the operation in progress.
REQ-013 On accepted start at edge k: latch operand magnitudes (|a|, |b| if sgn=1, else raw), latch sign = sgn & (a[BW-1] ^ b[BW-1]), clear accumulator, counter = 0, go to RUN.
REQ-014 RUN SHALL perform one shift-add step per cycle for exactly BW cycles:
- if multiplier LSB is 1, {carry, acc_hi} = acc_hi + mcand via the adder sub-module, cin = 0; otherwise no add.
- then shift {carry, acc_hi, mq} right one bit.
REQ-015 busy SHALL be 1 exactly in RUN (BW cycles following edge k), else 0.
REQ-016 At edge k+BW: load prod with the final 2*BW-bit result, two's-complement negated if the latched sign = 1; go to DONE.
REQ-017 done SHALL be 1 only in DONE (the single cycle after edge k+BW); DONE -> IDLE next edge unless start is accepted (-> RUN).
REQ-018 prod, zero, neg SHALL hold their values from DONE until the next load at REQ-016.
REQ-019 zero = (prod == 0); neg = prod[2*BW-1] when latched sgn = 1, else 0.
REQ-020 Signed magnitude of -2^(BW-1) SHALL be 2^(BW-1) treated as unsigned BW bits; no overflow exists at 2*BW result width.
REQ-021 Latency from accepted start to done SHALL be BW+1 cycles; back-to-back throughput SHALL be one result per BW+1 cycles.

Reset
REQ-022 rst high at a clock edge SHALL force IDLE and clear busy, done, prod, zero, neg, counter and all datapath registers to 0, overriding start.
REQ-023 rst asserted during RUN or DONE SHALL abort the operation with no done pulse.

Structure
REQ-024 A shared package SHALL hold the FSM state type (IDLE, RUN, DONE) and the default width constant 16.
REQ-025 The per-step addition SHALL use one instance of the existing ripple-carry adder sub-module rca with bw = BW. Its co output is the step carry; its neg and ov outputs are unused.
REQ-026 Magnitude conversion and final negation SHALL be local logic; no second multiplier or adder chain for the step add.

Verification
REQ-027 sgn=0, a=3, b=5, start at edge 0 -> busy cycles 1..16, done at cycle 17, prod=0x0000000F, zero=0, neg=0.
REQ-028 sgn=0, a=0xFFFF, b=0xFFFF -> prod=0xFFFE0001, neg=0; sgn=1 same operands -> prod=0x00000001, neg=0.
REQ-029 sgn=1, a=0x8000, b=0x8000 -> prod=0x40000000; sgn=1, a=0xFFFD (-3), b=5 -> prod=0xFFFFFFF1, neg=1.
REQ-030 a=0, b=0x1234 -> prod=0, zero=1; then start asserted in the DONE cycle with a=2, b=2 -> new run begins, done 17 cycles later, prod=4.
REQ-031 start re-asserted with a=7, b=7 during RUN of 3*5 -> ignored, result 15; rst pulse at cycle 8 of a run -> all outputs 0, no done, IDLE next cycle.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the default operand width.
package seq_mul_pkg;

  localparam int unsigned DefaultBw = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

endpackage

// File: rtl/rca.sv
// Ripple-carry adder: s = a + b + cin, with carry-out plus signed sign and
// overflow indicators of the sum.
module rca #(
  parameter int unsigned bw = 16
) (
  input  logic [bw-1:0] a,
  input  logic [bw-1:0] b,
  input  logic          cin,
  output logic [bw-1:0] s,
  output logic          co,
  output logic          neg,
  output logic          ov
);

  always_comb begin
    logic cy;
    logic cy_msb;
    cy     = cin;
    cy_msb = 1'b0;
    s      = '0;
    for (int i = 0; i < int'(bw); i++) begin
      if (i == int'(bw) - 1) cy_msb = cy;
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    co  = cy;
    neg = s[bw-1];
    // Signed overflow: carry into the MSB differs from carry out of it.
    ov  = cy_msb ^ cy;
  end

endmodule

// File: rtl/seq_mul.sv
// Sequential BW x BW multiplier: one shift-add step per cycle over BW cycles,
// signed operands handled by magnitude conversion and final negation.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int unsigned BW = DefaultBw
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sgn,
  input  logic [BW-1:0]   a,
  input  logic [BW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*BW-1:0] prod,
  output logic            zero,
  output logic            neg
);

  localparam int unsigned CntW = $clog2(BW) + 1;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]     mcand_q, mcand_d;
  logic [BW-1:0]     mq_q, mq_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic              sign_q, sign_d;
  logic              sgn_q, sgn_d;
  logic [2*BW-1:0]   prod_q, prod_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;

  logic [BW-1:0]     add_sum;
  logic              add_co;
  logic              add_neg_unused;
  logic              add_ov_unused;

  logic [BW-1:0]     a_mag, b_mag;
  logic [BW-1:0]     sel_sum;
  logic              sel_co;
  logic [BW-1:0]     shift_hi, shift_lo;
  logic [2*BW-1:0]   res, fin;

  rca #(
    .bw (BW)
  ) u_add (
    .a   (acc_q),
    .b   (mcand_q),
    .cin (1'b0),
    .s   (add_sum),
    .co  (add_co),
    .neg (add_neg_unused),
    .ov  (add_ov_unused)
  );

  // Step datapath: optional add, then shift {carry, acc, mq} right by one.
  always_comb begin
    a_mag    = (sgn && a[BW-1]) ? -a : a;
    b_mag    = (sgn && b[BW-1]) ? -b : b;
    sel_sum  = mq_q[0] ? add_sum : acc_q;
    sel_co   = mq_q[0] & add_co;
    shift_hi = {sel_co, sel_sum[BW-1:1]};
    shift_lo = {sel_sum[0], mq_q[BW-1:1]};
    res      = {shift_hi, shift_lo};
    fin      = sign_q ? -res : res;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    sgn_d   = sgn_q;
    prod_d  = prod_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mcand_d = a_mag;
          mq_d    = b_mag;
          acc_d   = '0;
          cnt_d   = '0;
          sign_d  = sgn & (a[BW-1] ^ b[BW-1]);
          sgn_d   = sgn;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_d = shift_hi;
        mq_d  = shift_lo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(BW - 1)) begin
          prod_d  = fin;
          zero_d  = (fin == '0);
          neg_d   = sgn_q & fin[2*BW-1];
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mcand_q <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      sgn_q   <= 1'b0;
      prod_q  <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      sgn_q   <= sgn_d;
      prod_q  <= prod_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign prod = prod_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: directed vectors, randomized operands
// against an arithmetic reference, back-to-back, ignored start and reset abort.
module tb_seq_mul;

  localparam int BW = 16;

  logic            clk;
  logic            rst;
  logic            start;
  logic            sgn;
  logic [BW-1:0]   a;
  logic [BW-1:0]   b;
  logic            busy;
  logic            done;
  logic [2*BW-1:0] prod;
  logic            zero;
  logic            neg;

  int pass_cnt;
  int total_cnt;

  seq_mul #(
    .BW (BW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .prod  (prod),
    .zero  (zero),
    .neg   (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier",
             $time);
    $fatal(1);
  end

  function automatic logic [2*BW-1:0] model_prod(input logic s, input logic [BW-1:0] x,
                                                 input logic [BW-1:0] y);
    longint px;
    logic [63:0] pv;
    if (s) px = longint'($signed(x)) * longint'($signed(y));
    else   px = longint'(x) * longint'(y);
    pv = px;
    return pv[2*BW-1:0];
  endfunction

  // Issue one operation and wait (bounded) for done; lat counts cycles from the
  // accepting edge to the edge that raises done.
  task automatic run_op(input logic s, input logic [BW-1:0] x, input logic [BW-1:0] y,
                        output logic [2*BW-1:0] p, output logic z, output logic n,
                        output int lat, output logic busy_ok, output logic busy_at_done);
    @(negedge clk);
    start = 1'b1;
    sgn   = s;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start   = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    p            = prod;
    z            = zero;
    n            = neg;
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    sgn   = 1'b1;
    a     = 16'hFFFF;
    b     = 16'h0003;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, prod, zero, neg} !== '0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b prod=%h zero=%b neg=%b, required all 0",
               busy, done, prod, zero, neg);
    end else pass_cnt++;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_idle: got busy=%b done=%b, required 0 0", busy, done);
    end else pass_cnt++;
  endtask

  task automatic test_directed();
    logic            ds[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [BW-1:0]   da[6] = '{16'h0003, 16'hFFFF, 16'hFFFF, 16'h8000, 16'hFFFD, 16'h0000};
    logic [BW-1:0]   db[6] = '{16'h0005, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0005, 16'h1234};
    logic [2*BW-1:0] dp[6] = '{32'h0000000F, 32'hFFFE0001, 32'h00000001, 32'h40000000,
                               32'hFFFFFFF1, 32'h00000000};
    logic            dz[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic            dn[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2*BW-1:0] p;
    logic            z, n, bok, bdone;
    int              lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ds[i], da[i], db[i], p, z, n, lat, bok, bdone);
      total_cnt++;
      if (p !== dp[i] || z !== dz[i] || n !== dn[i]) begin
        $display("FAIL directed_%0d: got prod=%h zero=%b neg=%b, required prod=%h zero=%b neg=%b",
                 i, p, z, n, dp[i], dz[i], dn[i]);
      end else pass_cnt++;
      total_cnt++;
      if (lat !== BW + 1 || bok !== 1'b1 || bdone !== 1'b0) begin
        $display("FAIL directed_timing_%0d: got lat=%0d busy_ok=%b busy_at_done=%b, required %0d 1 0",
                 i, lat, bok, bdone, BW + 1);
      end else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2*BW-1:0] p;
    logic            z, n, bok, bdone;
    int              lat;
    run_op(1'b0, 16'h0000, 16'h1234, p, z, n, lat, bok, bdone);
    total_cnt++;
    if (p !== '0 || z !== 1'b1) begin
      $display("FAIL b2b_first: got prod=%h zero=%b, required 0 1", p, z);
    end else pass_cnt++;
    // Still in the DONE cycle here, so this start is taken at the next edge.
    run_op(1'b0, 16'h0002, 16'h0002, p, z, n, lat, bok, bdone);
    total_cnt++;
    if (p !== 32'd4 || z !== 1'b0 || n !== 1'b0 || lat !== BW + 1) begin
      $display("FAIL b2b_second: got prod=%h zero=%b neg=%b lat=%0d, required 4 0 0 %0d",
               p, z, n, lat, BW + 1);
    end else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || prod !== 32'd4) begin
      $display("FAIL b2b_after: got done=%b busy=%b prod=%h, required 0 0 4", done, busy, prod);
    end else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int cyc;
    @(negedge clk);
    start = 1'b1;
    sgn   = 1'b0;
    a     = 16'd3;
    b     = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == 5) begin
        @(negedge clk);
        start = 1'b1;
        a     = 16'd7;
        b     = 16'd7;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    total_cnt++;
    if (prod !== 32'd15 || cyc !== BW + 1) begin
      $display("FAIL start_ignored: got prod=%h lat=%0d, required 0000000f %0d",
               prod, cyc, BW + 1);
    end else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic            saw_done;
    logic [2*BW-1:0] p;
    logic            z, n, bok, bdone;
    int              lat;
    @(negedge clk);
    start = 1'b1;
    sgn   = 1'b1;
    a     = 16'hFFFD;
    b     = 16'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, prod, zero, neg} !== '0) begin
      $display("FAIL abort_outputs: got busy=%b done=%b prod=%h zero=%b neg=%b, required all 0",
               busy, done, prod, zero, neg);
    end else pass_cnt++;
    rst      = 1'b0;
    saw_done = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0) begin
      $display("FAIL abort_idle: got busy=%b, required 0", busy);
    end else pass_cnt++;
    repeat (24) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk);
      #1;
    end
    total_cnt++;
    if (saw_done !== 1'b0) begin
      $display("FAIL abort_no_done: got done pulse=%b, required 0", saw_done);
    end else pass_cnt++;
    run_op(1'b1, 16'hFFFD, 16'd9, p, z, n, lat, bok, bdone);
    total_cnt++;
    if (p !== model_prod(1'b1, 16'hFFFD, 16'd9) || n !== 1'b1 || lat !== BW + 1) begin
      $display("FAIL abort_recover: got prod=%h neg=%b lat=%0d, required %h 1 %0d",
               p, n, lat, model_prod(1'b1, 16'hFFFD, 16'd9), BW + 1);
    end else pass_cnt++;
  endtask

  task automatic test_random();
    logic [BW-1:0]   corner[5] = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'h7FFF};
    logic [BW-1:0]   x, y;
    logic            s;
    logic [2*BW-1:0] p, ep;
    logic            z, n, bok, bdone, ez, en;
    int              lat;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : BW'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : BW'($urandom);
      ep = model_prod(s, x, y);
      ez = (ep == '0);
      en = s & ep[2*BW-1];
      run_op(s, x, y, p, z, n, lat, bok, bdone);
      total_cnt++;
      if (p !== ep || z !== ez || n !== en || lat !== BW + 1 || bok !== 1'b1) begin
        $display("FAIL random_%0d sgn=%b a=%h b=%h: got prod=%h zero=%b neg=%b lat=%0d busy_ok=%b, required prod=%h zero=%b neg=%b lat=%0d busy_ok=1",
                 i, s, x, y, p, z, n, lat, bok, ep, ez, en, BW + 1);
      end else pass_cnt++;
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    start     = 1'b0;
    sgn       = 1'b0;
    a         = '0;
    b         = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
